stack_op_master: RTL and testbench

- Initiator side of the stack32 push/trigger/done handshake.
- Accepts single operand-stack commands from the execute stage: push immediate, pop, dup, binary ALU op.
- Turns each command into the required sequence of stack32 pop/push transactions and returns a result.
- Sits between the bytecode execute control and the stack32 instance. Tracks stack depth so it never issues an underflowing or overflowing transaction.

---
 rtl/stack_pkg.sv | 32 +++
 rtl/stack_op_alu.sv | 26 ++
 rtl/stack_op_master.sv | 132 +++++++++++++
 tb/tb_stack_op_master.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared opcode/state encodings and data width for the stack32 initiator slice.
package stack_pkg;

  localparam int STACK_DW = 32;

  typedef enum logic [2:0] {
    OP_PUSH_IMM = 3'd0,
    OP_POP      = 3'd1,
    OP_ADD      = 3'd2,
    OP_SUB      = 3'd3,
    OP_AND      = 3'd4,
    OP_OR       = 3'd5,
    OP_XOR      = 3'd6,
    OP_DUP      = 3'd7
  } stack_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_POP_REQ,
    S_POP_WAIT,
    S_EXEC,
    S_PUSH_REQ,
    S_PUSH_WAIT,
    S_RESP
  } master_state_e;

  function automatic logic is_alu(stack_op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/stack_op_alu.sv
// Combinational result of a stack command from operands A (deeper) and B (top).
// Non-ALU ops pass B through: the immediate for PUSH_IMM, the popped word for POP/DUP.
module stack_op_alu
  import stack_pkg::*;
#(
  parameter int DW = STACK_DW
) (
  input  stack_op_e        op_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [DW-1:0]    res_o
);

  always_comb begin
    res_o = b_i;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = b_i;
    endcase
  end

endmodule

// File: rtl/stack_op_master.sv
// Initiator for the stack32 push/trigger/done handshake: turns one operand-stack
// command into its pop/push transactions, tracking depth to refuse over/underflow.
module stack_op_master
  import stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = STACK_DW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [DW-1:0]                cmd_imm,
  output logic                         resp_valid,
  output logic [DW-1:0]                resp_value,
  output logic                         resp_error,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stk_push,
  output logic                         stk_trigger,
  output logic [DW-1:0]                stk_write_value,
  input  logic [DW-1:0]                stk_read_value,
  input  logic                         stk_done
);

  localparam int DPW = $clog2(DEPTH+1);
  localparam logic [DPW-1:0] DEPTH_W = DPW'(DEPTH);

  master_state_e   state_q, state_d;
  stack_op_e       op_q;
  logic [DW-1:0]   a_q, b_q, wr_q, rv_q;
  logic [1:0]      cnt_q;
  logic [DPW-1:0]  depth_q;
  logic            re_q;
  logic            err;
  logic [DW-1:0]   alu_res;

  stack_op_alu #(.DW(DW)) u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  always_comb begin
    case (op_q)
      OP_PUSH_IMM: err = (depth_q >= DEPTH_W);
      OP_POP:      err = (depth_q == '0);
      OP_DUP:      err = (depth_q == '0) || (depth_q >= DEPTH_W);
      default:     err = (depth_q < DPW'(2));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cmd_valid) state_d = S_CHECK;
      S_CHECK:     state_d = err ? S_RESP : (op_q == OP_PUSH_IMM) ? S_PUSH_REQ : S_POP_REQ;
      S_POP_REQ:   state_d = S_POP_WAIT;
      S_POP_WAIT:  if (stk_done) state_d = (cnt_q == 2'd1) ? S_EXEC : S_POP_REQ;
      S_EXEC:      state_d = (op_q == OP_POP) ? S_RESP : S_PUSH_REQ;
      S_PUSH_REQ:  state_d = S_PUSH_WAIT;
      S_PUSH_WAIT: if (stk_done) state_d = (cnt_q == 2'd1) ? S_RESP : S_PUSH_REQ;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_q == S_IDLE);
    stk_trigger     = (state_q == S_POP_REQ) || (state_q == S_PUSH_REQ);
    stk_push        = (state_q == S_PUSH_REQ);
    resp_valid      = (state_q == S_RESP);
    resp_error      = (state_q == S_RESP) && re_q;
    resp_value      = rv_q;
    depth           = depth_q;
    // The ALU result goes out in EXEC so it leads the push trigger by a cycle.
    stk_write_value = (state_q == S_EXEC) ? alu_res : wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_PUSH_IMM;
      a_q     <= '0;
      b_q     <= '0;
      wr_q    <= '0;
      rv_q    <= '0;
      re_q    <= 1'b0;
      cnt_q   <= '0;
      depth_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q <= stack_op_e'(cmd_op);
          b_q  <= cmd_imm;
          wr_q <= cmd_imm;
        end
        S_CHECK: begin
          re_q  <= err;
          cnt_q <= is_alu(op_q) ? 2'd2 : 2'd1;
          if (err) rv_q <= '0;
        end
        S_POP_WAIT: if (stk_done) begin
          if (is_alu(op_q) && cnt_q == 2'd1) a_q <= stk_read_value;
          else                               b_q <= stk_read_value;
          depth_q <= depth_q - DPW'(1);
          cnt_q   <= cnt_q - 2'd1;
        end
        S_EXEC: begin
          wr_q  <= alu_res;
          cnt_q <= (op_q == OP_DUP) ? 2'd2 : 2'd1;
          if (op_q == OP_POP) rv_q <= b_q;
        end
        S_PUSH_WAIT: if (stk_done) begin
          depth_q <= depth_q + DPW'(1);
          cnt_q   <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) rv_q <= wr_q;
        end
        default: ;
      endcase
    end
  end

  a_done_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    stk_done |-> (state_q == S_POP_WAIT || state_q == S_PUSH_WAIT));

endmodule

// File: tb/tb_stack_op_master.sv
// Directed bench for stack_op_master against a behavioural stack32 responder.
module tb_stack_op_master;
  import stack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_imm = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_value;
  logic        resp_error;
  logic [8:0]  depth;
  logic        stk_push;
  logic        stk_trigger;
  logic [31:0] stk_write_value;
  logic [31:0] stk_read_value = 32'd0;
  logic        stk_done = 1'b0;

  always #5 clk = ~clk;

  stack_op_master #(.DEPTH(256), .DW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_imm         (cmd_imm),
    .resp_valid      (resp_valid),
    .resp_value      (resp_value),
    .resp_error      (resp_error),
    .depth           (depth),
    .stk_push        (stk_push),
    .stk_trigger     (stk_trigger),
    .stk_write_value (stk_write_value),
    .stk_read_value  (stk_read_value),
    .stk_done        (stk_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [31:0] val; logic err; } exp_t;
  exp_t exp_q[$];

  // stack32 model: completes each transaction dly cycles after the trigger cycle + 1
  int          dly = 0;
  int          push_trigs = 0, pop_trigs = 0, overlap = 0, unstable = 0, model_uf = 0;
  logic [31:0] mem[$];

  initial begin : responder
    bit          busy;
    bit          lpush;
    int          cnt;
    logic [31:0] lval;
    busy = 0; lpush = 0; cnt = 0; lval = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 0; mem.delete(); stk_done = 1'b0; stk_read_value = 32'd0;
      end else begin
        stk_done = 1'b0;
        if (busy) begin
          if (stk_trigger) overlap++;
          if (lpush && stk_write_value !== lval) unstable++;
          if (cnt == 0) begin
            if (lpush) mem.push_back(lval);
            else if (mem.size() == 0) begin model_uf++; stk_read_value = 32'd0; end
            else stk_read_value = mem.pop_back();
            stk_done = 1'b1;
            busy = 0;
          end else cnt--;
        end else if (stk_trigger) begin
          busy = 1; cnt = dly; lpush = stk_push; lval = stk_write_value;
          if (stk_push) push_trigs++; else pop_trigs++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input stack_op_e op, input logic [31:0] imm, input logic [31:0] ev,
                        input logic ee, input int edepth, input int elat, input string tag);
    exp_t e;
    int   lat;
    int   w;
    e.val = ev; e.err = ee;
    exp_q.push_back(e);
    w = 0;
    while (!cmd_ready && w < 200) begin @(posedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
    e = exp_q.pop_front();
    if (resp_valid) begin
      check({tag, "_value"}, 64'(resp_value), 64'(e.val));
      check({tag, "_error"}, 64'(resp_error), 64'(e.err));
      check({tag, "_depth"}, 64'(depth), 64'(edepth));
      if (elat > 0) check({tag, "_latency"}, 64'(lat), 64'(elat));
    end
  endtask

  initial begin : main
    int p0, q0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_value", 64'(resp_value), 64'd0);
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_trigger", 64'(stk_trigger), 64'd0);
    check("rst_wval", 64'(stk_write_value), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // push then pop
    p0 = push_trigs; q0 = pop_trigs;
    do_cmd(OP_PUSH_IMM, 32'hcafebabe, 32'hcafebabe, 1'b0, 1, 0, "push_cafe");
    check("push_cafe_pushes", 64'(push_trigs - p0), 64'd1);
    check("push_cafe_pops", 64'(pop_trigs - q0), 64'd0);
    do_cmd(OP_POP, 32'h0, 32'hcafebabe, 1'b0, 0, 0, "pop_cafe");
    check("pop_cafe_pops", 64'(pop_trigs - q0), 64'd1);

    // SUB operand order
    do_cmd(OP_PUSH_IMM, 32'hdeadbeef, 32'hdeadbeef, 1'b0, 1, 0, "push_dead");
    do_cmd(OP_PUSH_IMM, 32'hb105f00d, 32'hb105f00d, 1'b0, 2, 0, "push_b105");
    p0 = push_trigs; q0 = pop_trigs;
    do_cmd(OP_SUB, 32'h0, 32'h2da7cee2, 1'b0, 1, 9, "sub");
    check("sub_pops", 64'(pop_trigs - q0), 64'd2);
    check("sub_pushes", 64'(push_trigs - p0), 64'd1);
    do_cmd(OP_POP, 32'h0, 32'h2da7cee2, 1'b0, 0, 0, "pop_sub");

    // ADD wrap
    do_cmd(OP_PUSH_IMM, 32'hffffffff, 32'hffffffff, 1'b0, 1, 0, "push_ff");
    do_cmd(OP_PUSH_IMM, 32'h00000002, 32'h00000002, 1'b0, 2, 0, "push_2");
    do_cmd(OP_ADD, 32'h0, 32'h00000001, 1'b0, 1, 9, "add_wrap");
    do_cmd(OP_POP, 32'h0, 32'h00000001, 1'b0, 0, 0, "pop_add");

    // underflow errors
    p0 = push_trigs; q0 = pop_trigs;
    do_cmd(OP_POP, 32'h0, 32'h0, 1'b1, 0, 2, "pop_empty");
    check("pop_empty_triggers", 64'((push_trigs - p0) + (pop_trigs - q0)), 64'd0);
    do_cmd(OP_PUSH_IMM, 32'h00000005, 32'h00000005, 1'b0, 1, 0, "push_5");
    p0 = push_trigs; q0 = pop_trigs;
    do_cmd(OP_ADD, 32'h0, 32'h0, 1'b1, 1, 2, "add_short");
    check("add_short_triggers", 64'((push_trigs - p0) + (pop_trigs - q0)), 64'd0);
    do_cmd(OP_POP, 32'h0, 32'h00000005, 1'b0, 0, 0, "pop_5");

    // DUP with a slow stack
    do_cmd(OP_PUSH_IMM, 32'h12345678, 32'h12345678, 1'b0, 1, 0, "push_1234");
    dly = 10;
    p0 = push_trigs; q0 = pop_trigs;
    do_cmd(OP_DUP, 32'h0, 32'h12345678, 1'b0, 2, 0, "dup");
    check("dup_pushes", 64'(push_trigs - p0), 64'd2);
    check("dup_pops", 64'(pop_trigs - q0), 64'd1);
    do_cmd(OP_POP, 32'h0, 32'h12345678, 1'b0, 1, 0, "dup_pop1");
    do_cmd(OP_POP, 32'h0, 32'h12345678, 1'b0, 0, 0, "dup_pop2");
    dly = 0;

    // reset during ADD pop wait
    do_cmd(OP_PUSH_IMM, 32'hffffffff, 32'hffffffff, 1'b0, 1, 0, "push_ff2");
    do_cmd(OP_PUSH_IMM, 32'h00000002, 32'h00000002, 1'b0, 2, 0, "push_22");
    dly = 10;
    while (!cmd_ready) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_imm = 32'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_depth", 64'(depth), 64'd0);
    check("midrst_trigger", 64'(stk_trigger), 64'd0);
    check("midrst_push", 64'(stk_push), 64'd0);
    check("midrst_wval", 64'(stk_write_value), 64'd0);
    check("midrst_resp_value", 64'(resp_value), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_resp_error", 64'(resp_error), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dly = 0;
    @(posedge clk); #1;
    check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("postrst_depth", 64'(depth), 64'd0);
    do_cmd(OP_PUSH_IMM, 32'h00000001, 32'h00000001, 1'b0, 1, 0, "postrst_push");

    check("no_trigger_overlap", 64'(overlap), 64'd0);
    check("wval_stable", 64'(unstable), 64'd0);
    check("no_model_underflow", 64'(model_uf), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
